character_motion: RTL
=====================

# character_motion

Tracks the player character's column and pixel position during play and drives the `character_landed` and `jump_fail` inputs of the game state machine. It consumes that machine's one-cycle `jump_left` / `jump_right` pulses and its `start_screen_en` level, and advances motion once per video frame. It queries the block map for the character's column and feeds `xpos` / `ypos` to the character sprite renderer.

## Interface
Parameters:
- COLS, 8: number of block columns.
- HOME_COL, 3: column after game reset.
- X0, 32: x pixel of column 0.
- BLOCK_W, 64: column pitch in pixels; must be a multiple of JUMP_FRAMES.
- Y_BASE, 400: standing y pixel.
- JUMP_FRAMES, 16: frames per jump; must be even.
- RISE, 4: y pixels per frame, up then down.
- FALL_STEP, 8: y pixels per frame while falling.
- FLOOR_Y, 560: y at which a fall ends.

Ports:
- clk in 1: system clock; the only clock.
- rst in 1: asynchronous, active-low reset.
- frame_tick in 1: one-cycle pulse per frame.
- game_reset in 1: level; connect to `start_screen_en`.
- jump_left in 1: one-cycle jump request.
- jump_right in 1: one-cycle jump request.
- block_present in 1: combinational map answer for `col`.
- col out clog2(COLS): current or target column.
- xpos out 11: character x pixel.
- ypos out 11: character y pixel.
- character_landed out 1: one-cycle pulse.
- jump_fail out 1: level.

## Operation
States:
- S_STAND
- S_FLY
- S_FALL
- S_DEAD

Reset and game reset:
- rst low or game_reset high forces S_STAND, `col`=HOME_COL, `xpos`=X0+HOME_COL·BLOCK_W, `ypos`=Y_BASE, `character_landed`=0, `jump_fail`=0.
- game_reset has priority over all other inputs and takes effect mid-flight or mid-fall.

S_STAND, jump start:
- In S_STAND with `jump_fail`=0, exactly one of jump_left/jump_right high starts a jump.
- Both high, or either high in any other state, is ignored. Requests are not queued.
- On start, `col` updates immediately to the target (col∓1), so the map lookup settles during flight.
- Target beyond 0 or COLS-1: `col` holds and internal `off_map`=1.
- Phase counter cleared; go to S_FLY.

S_FLY, per frame_tick:
- `xpos` moves ±BLOCK_W/JUMP_FRAMES.
- `ypos` moves −RISE for the first JUMP_FRAMES/2 ticks, then +RISE.
- If `off_map`, `xpos` keeps moving off the grid.
- On the JUMP_FRAMES-th tick:
  - `ypos`=Y_BASE exactly.
  - `character_landed` pulses.
  - `jump_fail` <= off_map | !block_present.
  - Go to S_STAND.

S_STAND with `jump_fail`=1:
- The next frame_tick enters S_FALL.
- In S_FALL, `ypos` += FALL_STEP per tick.
- At ≥FLOOR_Y: clamp to FLOOR_Y, pulse `character_landed`, go to S_DEAD.

S_DEAD:
- Holds until game_reset.
- `jump_fail` stays 1 through S_FALL and S_DEAD.

Widths:
- `xpos` / `ypos` are 11-bit unsigned.
- Parameters are checked so no step crosses 0 or 2047.

## Timing
- Jump pulse at edge N: S_FLY and new `col` visible after edge N.
- Landing on frame_tick edge M: `character_landed`=1 for exactly the cycle after M. `jump_fail` is valid in that same cycle, before the state machine re-enters GAME_IDLE.
- frame_tick coincident with a jump pulse in S_STAND: the jump starts and that tick is not counted as motion.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `CHARACTER_MOTION_COUNT_EN` defined:
  - Adds output `jump_count` (8 bits).
  - Increments on each landing with `jump_fail`=0; saturates at 255.
  - Cleared by rst / game_reset.
- Undefined: no port and no logic.

## Structure
- Shared package `skyhop_pkg`:
  - State encoding typedef for S_STAND..S_DEAD.
  - Screen-geometry constants (X0, BLOCK_W, Y_BASE, FLOOR_Y) shared with the block and sprite renderers.
- One sub-module, `frame_step_counter`: phase counter (0..JUMP_FRAMES-1) with clear, frame_tick enable and a terminal-count flag.

## Test plan
- Reset, then release: col=3, xpos=224, ypos=400, character_landed=0, jump_fail=0.
- jump_right, block_present=1, 16 ticks:
  - col=4 right after the pulse.
  - ypos=368 after tick 8.
  - After tick 16: xpos=288, ypos=400, one landed pulse, jump_fail=0.
- jump_left from col 0:
  - col stays 0.
  - After 16 ticks: xpos=−32 wraps to 2016.
  - One landed pulse; jump_fail=1.
  - Next tick enters fall; ypos reaches 560, second landed pulse, then holds.
- jump_right landing with block_present=0: jump_fail=1 in the landed cycle; fall follows.
- game_reset asserted mid-flight at tick 5: next cycle home position, S_STAND; no landed pulse.
- Jump pulse during S_FLY, and jump_left with jump_right together in S_STAND: both ignored; position unchanged.

Source files
------------

// File: rtl/skyhop_pkg.sv
// Shared definitions for the skyhop game: character motion states and the
// screen geometry used by the motion, block and sprite logic.
package skyhop_pkg;

  typedef enum logic [1:0] {
    S_STAND = 2'd0,
    S_FLY   = 2'd1,
    S_FALL  = 2'd2,
    S_DEAD  = 2'd3
  } motion_state_t;

  localparam int POS_W       = 11;
  localparam int SCR_X0      = 32;
  localparam int SCR_BLOCK_W = 64;
  localparam int SCR_Y_BASE  = 400;
  localparam int SCR_FLOOR_Y = 560;

endpackage

// File: rtl/frame_step_counter.sv
// Jump phase counter: counts enabled frame ticks 0..N_STEPS-1 and flags the
// last phase so the owner can finish the move on that tick.
module frame_step_counter #(
  parameter int N_STEPS = 16,
  parameter int PH_W    = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [PH_W-1:0] phase,
  output logic            tc
);

  assign tc = (phase == PH_W'(N_STEPS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= tc ? '0 : phase + PH_W'(1);
    end
  end

endmodule

// File: rtl/character_motion.sv
// Player character column / pixel tracker driving landing and jump-fail
// status. Optional landing counter: define CHARACTER_MOTION_COUNT_EN.
module character_motion
  import skyhop_pkg::*;
#(
  parameter int COLS        = 8,
  parameter int HOME_COL    = 3,
  parameter int X0          = SCR_X0,
  parameter int BLOCK_W     = SCR_BLOCK_W,
  parameter int Y_BASE      = SCR_Y_BASE,
  parameter int JUMP_FRAMES = 16,
  parameter int RISE        = 4,
  parameter int FALL_STEP   = 8,
  parameter int FLOOR_Y     = SCR_FLOOR_Y
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     game_reset,
  input  logic                     jump_left,
  input  logic                     jump_right,
  input  logic                     block_present,
  output logic [$clog2(COLS)-1:0]  col,
  output logic [POS_W-1:0]         xpos,
  output logic [POS_W-1:0]         ypos,
  output logic                     character_landed,
  output logic                     jump_fail
`ifdef CHARACTER_MOTION_COUNT_EN
  ,
  output logic [7:0]               jump_count
`endif
);

  localparam int CW   = $clog2(COLS);
  localparam int PH_W = (JUMP_FRAMES > 1) ? $clog2(JUMP_FRAMES) : 1;
  localparam int HALF = JUMP_FRAMES / 2;

  localparam logic [POS_W-1:0] X_HOME   = POS_W'(X0 + HOME_COL * BLOCK_W);
  localparam logic [POS_W-1:0] X_STEP   = POS_W'(BLOCK_W / JUMP_FRAMES);
  localparam logic [POS_W-1:0] Y_STAND  = POS_W'(Y_BASE);
  localparam logic [POS_W-1:0] Y_RISE   = POS_W'(RISE);
  localparam logic [POS_W:0]   Y_FSTEP  = (POS_W + 1)'(FALL_STEP);
  localparam logic [POS_W:0]   Y_FLOOR  = (POS_W + 1)'(FLOOR_Y);
  localparam logic [CW-1:0]    COL_HOME = CW'(HOME_COL);
  localparam logic [CW-1:0]    COL_MAX  = CW'(COLS - 1);

  // Geometry must keep every vertical step inside the 11-bit pixel range.
  if ((BLOCK_W % JUMP_FRAMES) != 0 || (JUMP_FRAMES % 2) != 0 ||
      HOME_COL < 0 || HOME_COL >= COLS ||
      (Y_BASE - RISE * HALF) < 0 || (FLOOR_Y + FALL_STEP) > 2047 ||
      FLOOR_Y < Y_BASE) begin : g_param_err
    $error("character_motion: illegal parameter combination");
  end

  motion_state_t    state, state_n;
  logic [CW-1:0]    col_n;
  logic [POS_W-1:0] xpos_n, ypos_n;
  logic             landed_n, fail_n;
  logic             dir_right, dir_right_n;
  logic             off_map, off_map_n;
  logic             jump_start;
  logic [PH_W-1:0]  phase;
  logic             phase_tc;
  logic [POS_W:0]   fall_sum;

  frame_step_counter #(
    .N_STEPS (JUMP_FRAMES),
    .PH_W    (PH_W)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clr   (jump_start | game_reset),
    .en    (frame_tick & (state == S_FLY)),
    .phase (phase),
    .tc    (phase_tc)
  );

  assign fall_sum = {1'b0, ypos} + Y_FSTEP;

  always_comb begin
    state_n     = state;
    col_n       = col;
    xpos_n      = xpos;
    ypos_n      = ypos;
    dir_right_n = dir_right;
    off_map_n   = off_map;
    landed_n    = 1'b0;
    fail_n      = jump_fail;
    jump_start  = 1'b0;

    if (game_reset) begin
      state_n     = S_STAND;
      col_n       = COL_HOME;
      xpos_n      = X_HOME;
      ypos_n      = Y_STAND;
      dir_right_n = 1'b0;
      off_map_n   = 1'b0;
      fail_n      = 1'b0;
    end else begin
      unique case (state)
        S_STAND: begin
          // A jump takes precedence over any coincident frame tick.
          if (!jump_fail && (jump_left ^ jump_right)) begin
            jump_start  = 1'b1;
            state_n     = S_FLY;
            dir_right_n = jump_right;
            off_map_n   = 1'b0;
            if (jump_right) begin
              if (col == COL_MAX) off_map_n = 1'b1;
              else                col_n     = col + CW'(1);
            end else begin
              if (col == '0) off_map_n = 1'b1;
              else           col_n     = col - CW'(1);
            end
          end else if (jump_fail && frame_tick) begin
            state_n = S_FALL;
          end
        end
        S_FLY: begin
          if (frame_tick) begin
            xpos_n = dir_right ? xpos + X_STEP : xpos - X_STEP;
            ypos_n = (phase < PH_W'(HALF)) ? ypos - Y_RISE : ypos + Y_RISE;
            if (phase_tc) begin
              ypos_n   = Y_STAND;
              landed_n = 1'b1;
              fail_n   = off_map | ~block_present;
              state_n  = S_STAND;
            end
          end
        end
        S_FALL: begin
          if (frame_tick) begin
            if (fall_sum >= Y_FLOOR) begin
              ypos_n   = Y_FLOOR[POS_W-1:0];
              landed_n = 1'b1;
              state_n  = S_DEAD;
            end else begin
              ypos_n = fall_sum[POS_W-1:0];
            end
          end
        end
        S_DEAD: begin
          state_n = S_DEAD;
        end
        default: begin
          state_n = S_STAND;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_STAND;
      col              <= COL_HOME;
      xpos             <= X_HOME;
      ypos             <= Y_STAND;
      dir_right        <= 1'b0;
      off_map          <= 1'b0;
      character_landed <= 1'b0;
      jump_fail        <= 1'b0;
    end else begin
      state            <= state_n;
      col              <= col_n;
      xpos             <= xpos_n;
      ypos             <= ypos_n;
      dir_right        <= dir_right_n;
      off_map          <= off_map_n;
      character_landed <= landed_n;
      jump_fail        <= fail_n;
    end
  end

`ifdef CHARACTER_MOTION_COUNT_EN
  // Only successful jump landings count; fall landings are excluded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jump_count <= '0;
    end else if (game_reset) begin
      jump_count <= '0;
    end else if (state == S_FLY && landed_n && !fail_n && jump_count != 8'hFF) begin
      jump_count <= jump_count + 8'd1;
    end
  end
`endif

endmodule
